// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// DEFAULT_DEPTH/DEFAULT_ADDR_W are also the sizing source for instMemory.
package imem_boot_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = 2;
    localparam int DEFAULT_DEPTH  = 64;
    localparam int DEFAULT_ADDR_W = 6;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } load_state_t;

    // Bit position of the low bit of a byte lane inside a 32-bit word.
    function automatic logic [4:0] lane_lsb(input logic [LANE_W-1:0] lane,
                                            input logic big_endian);
        logic [LANE_W-1:0] slot;
        slot = big_endian ? (LANE_W'(BYTES_PER_WORD - 1) - lane) : lane;
        return {slot, 3'b000};
    endfunction

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Packing register that assembles bytes into a 32-bit word, lane by lane.
// word_out is the word as it would be with byte_in placed on the current lane.
module imem_boot_loader_byte_packer
    import imem_boot_loader_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [LANE_W-1:0] lane,
    input  logic [7:0]        byte_in,
    output logic [31:0]       word_out
);

    logic [31:0] pack_q;

    // Only lanes below the current one carry earlier bytes; every lane above
    // it reads as 0x00, which is what zero-fills a short final word.
    always_comb begin
        word_out = '0;
        for (int l = 0; l < BYTES_PER_WORD; l++) begin
            if (LANE_W'(l) < lane) begin
                word_out[lane_lsb(LANE_W'(l), BIG_ENDIAN) +: 8] =
                    pack_q[lane_lsb(LANE_W'(l), BIG_ENDIAN) +: 8];
            end
        end
        word_out[lane_lsb(lane, BIG_ENDIAN) +: 8] = byte_in;
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            pack_q <= '0;
        end else if (load) begin
            pack_q <= word_out;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams bytes into 32-bit instruction words, writes them to instruction
// memory and holds the core until the whole image has been written.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              reload,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W:0]   word_count,
    output logic              core_hold,
    output logic              load_done,
    output logic              error,
    output logic [1:0]        dbg_state
);

    localparam int COUNT_W = ADDR_W + 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

    load_state_t         state_q, state_d;
    logic [LANE_W-1:0]   lane_q;
    logic [COUNT_W-1:0]  word_count_q;
    logic                accept;
    logic                overflow;
    logic                write_trig;
    logic                do_reload;
    logic [31:0]         packed_next;

    // Handshake: a byte moves when in_valid && in_ready in the same cycle;
    // in_data/in_last are looked at only then, and in_ready depends on state
    // alone, so the source may hold in_valid for as long as it needs.
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        accept     = 1'b0;
        overflow   = 1'b0;
        write_trig = 1'b0;
        do_reload  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (accept) begin
                    if (word_count_q == COUNT_W'(DEPTH) && lane_q == '0) begin
                        overflow = 1'b1;
                        state_d  = ST_ERROR;
                    end else begin
                        write_trig = (lane_q == LAST_LANE) || in_last;
                        if (in_last) state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE: begin
                if (reload) begin
                    do_reload = 1'b1;
                    state_d   = ST_LOAD;
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_LOAD;
        else       state_q <= state_d;
    end

    // An overflowing byte is dropped: it neither advances the lane nor packs.
    always_ff @(posedge clock) begin
        if (reset) begin
            lane_q       <= '0;
            word_count_q <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
        end else begin
            wr_en <= write_trig;
            if (write_trig) begin
                wr_addr      <= word_count_q[ADDR_W-1:0];
                wr_data      <= packed_next;
                word_count_q <= word_count_q + COUNT_W'(1);
                lane_q       <= '0;
            end else if (accept && !overflow) begin
                lane_q <= lane_q + LANE_W'(1);
            end
            if (do_reload) begin
                word_count_q <= '0;
                lane_q       <= '0;
            end
        end
    end

    imem_boot_loader_byte_packer #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_packer (
        .clock   (clock),
        .reset   (reset),
        .load    (accept && !overflow),
        .clear   (write_trig || overflow || do_reload),
        .lane    (lane_q),
        .byte_in (in_data),
        .word_out(packed_next)
    );

    assign word_count = word_count_q;
    assign core_hold  = (state_q != ST_DONE);
    assign load_done  = (state_q == ST_DONE);
    assign error      = (state_q == ST_ERROR);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: three instances (default, DEPTH=4, little-endian)
// share one byte stream; a byte-list model predicts every memory write.
module tb_imem_boot_loader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       reload = 1'b0;

  logic m_in_ready, m_wr_en, m_core_hold, m_load_done, m_error;
  logic [5:0] m_wr_addr; logic [31:0] m_wr_data; logic [6:0] m_word_count; logic [1:0] m_state;
  logic s_in_ready, s_wr_en, s_core_hold, s_load_done, s_error;
  logic [1:0] s_wr_addr; logic [31:0] s_wr_data; logic [2:0] s_word_count; logic [1:0] s_state;
  logic l_in_ready, l_wr_en, l_core_hold, l_load_done, l_error;
  logic [5:0] l_wr_addr; logic [31:0] l_wr_data; logic [6:0] l_word_count; logic [1:0] l_state;

  imem_boot_loader #(.DEPTH(64), .ADDR_W(6), .BIG_ENDIAN(1'b1)) u_main (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(m_in_ready), .reload(reload), .wr_en(m_wr_en), .wr_addr(m_wr_addr),
    .wr_data(m_wr_data), .word_count(m_word_count), .core_hold(m_core_hold),
    .load_done(m_load_done), .error(m_error), .dbg_state(m_state));

  imem_boot_loader #(.DEPTH(4), .ADDR_W(2), .BIG_ENDIAN(1'b1)) u_small (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(s_in_ready), .reload(reload), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
    .wr_data(s_wr_data), .word_count(s_word_count), .core_hold(s_core_hold),
    .load_done(s_load_done), .error(s_error), .dbg_state(s_state));

  imem_boot_loader #(.DEPTH(64), .ADDR_W(6), .BIG_ENDIAN(1'b0)) u_le (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(l_in_ready), .reload(reload), .wr_en(l_wr_en), .wr_addr(l_wr_addr),
    .wr_data(l_wr_data), .word_count(l_word_count), .core_hold(l_core_hold),
    .load_done(l_load_done), .error(l_error), .dbg_state(l_state));

  int vectors = 0;
  int miscompares = 0;
  bit use_small = 1'b0;
  logic tgt_ready;
  logic [1:0] load_code;
  assign tgt_ready = use_small ? s_in_ready : m_in_ready;

  // Observed writes per instance, and the model's byte list / expected words.
  logic [31:0] m_data_q[$]; int m_addr_q[$];
  logic [31:0] s_data_q[$]; int s_addr_q[$];
  logic [31:0] l_data_q[$]; int l_addr_q[$];
  logic [7:0]  model_bytes[$];
  logic [31:0] exp_q[$];

  always @(negedge clock) begin
    if (m_wr_en) begin m_data_q.push_back(m_wr_data); m_addr_q.push_back(int'(m_wr_addr)); end
    if (s_wr_en) begin s_data_q.push_back(s_wr_data); s_addr_q.push_back(int'(s_wr_addr)); end
    if (l_wr_en) begin l_data_q.push_back(l_wr_data); l_addr_q.push_back(int'(l_wr_addr)); end
  end

  // Reference: the image is cut into 4-byte groups, the short tail padded with zeros.
  function automatic void build_expected(input bit be);
    logic [31:0] w;
    logic [7:0]  b;
    exp_q.delete();
    for (int i = 0; i < model_bytes.size(); i += 4) begin
      w = 32'h0;
      for (int j = 0; j < 4; j++) begin
        b = (i + j < model_bytes.size()) ? model_bytes[i + j] : 8'h00;
        if (be) w = w | ({24'h0, b} << (8 * (3 - j)));
        else    w = w | ({24'h0, b} << (8 * j));
      end
      exp_q.push_back(w);
    end
  endfunction

  task automatic clear_capture;
    m_data_q.delete(); m_addr_q.delete();
    s_data_q.delete(); s_addr_q.delete();
    l_data_q.delete(); l_addr_q.delete();
  endtask

  task automatic do_reset;
    @(posedge clock); #1;
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; reload = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b0;
    clear_capture();
    model_bytes.delete();
  endtask

  // Returns just after the edge that accepted the byte.
  task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
    bit ok;
    ok = 1'b0;
    repeat (gap) begin @(posedge clock); #1; end
    in_valid = 1'b1; in_data = b; in_last = last;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (tgt_ready) begin ok = 1'b1; break; end
    end
    @(posedge clock); #1;
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'($urandom_range(0, 255));
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL accept_byte %h: in_ready=%b, required 1 within 20 cycles", b, tgt_ready);
    end
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clock);
    load_code = m_state;
    vectors++;
    if ({m_wr_en, m_wr_addr, m_wr_data, m_word_count} !== 46'h0) begin
      miscompares++;
      $display("FAIL reset_write_port: en=%b addr=%0d data=%h count=%0d, required all 0",
               m_wr_en, m_wr_addr, m_wr_data, m_word_count);
    end
    vectors++;
    if ({m_core_hold, m_load_done, m_error, m_in_ready} !== 4'b1001) begin
      miscompares++;
      $display("FAIL reset_status: hold/done/err/rdy=%b%b%b%b, required 1001",
               m_core_hold, m_load_done, m_error, m_in_ready);
    end
    vectors++;
    if ({s_core_hold, s_load_done, s_error, s_in_ready, s_word_count} !== 7'b1001_000) begin
      miscompares++;
      $display("FAIL reset_small: hold/done/err/rdy=%b%b%b%b count=%0d, required 1001 0",
               s_core_hold, s_load_done, s_error, s_in_ready, s_word_count);
    end
    vectors++;
    if ({l_wr_en, l_wr_data, l_state} !== {1'b0, 32'h0, load_code}) begin
      miscompares++;
      $display("FAIL reset_le: en=%b data=%h state=%0d, required 0 0 %0d",
               l_wr_en, l_wr_data, l_state, load_code);
    end
  endtask

  task automatic test_basic;
    logic [7:0] bl [0:7];
    bl = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    use_small = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) send_byte(bl[i], (i == 7), 0);
    @(negedge clock);
    vectors++;
    if ({m_wr_en, m_wr_addr, m_wr_data, m_core_hold, m_load_done} !== {1'b1, 6'd1, 32'h8C090004, 2'b10}) begin
      miscompares++;
      $display("FAIL basic_flush: en=%b addr=%0d data=%h hold=%b done=%b, required 1 1 8c090004 1 0",
               m_wr_en, m_wr_addr, m_wr_data, m_core_hold, m_load_done);
    end
    @(negedge clock);
    vectors++;
    if ({m_core_hold, m_load_done, m_wr_en, m_word_count} !== {3'b010, 7'd2}) begin
      miscompares++;
      $display("FAIL basic_done: hold=%b done=%b en=%b count=%0d, required 0 1 0 2",
               m_core_hold, m_load_done, m_wr_en, m_word_count);
    end
    @(posedge clock); #1;
    vectors++;
    if (m_data_q.size() != 2) begin
      miscompares++;
      $display("FAIL basic_write_count: got %0d writes, required 2", m_data_q.size());
    end else if (m_data_q[0] !== 32'h20080005 || m_addr_q[0] != 0 || m_addr_q[1] != 1) begin
      miscompares++;
      $display("FAIL basic_word0: addr %0d data %h (next addr %0d), required addr 0 data 20080005 (next 1)",
               m_addr_q[0], m_data_q[0], m_addr_q[1]);
    end
  endtask

  task automatic test_partial_word;
    logic [7:0] bl [0:5];
    bl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    use_small = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(bl[i], (i == 5), 0);
    repeat (3) begin @(posedge clock); #1; end
    vectors++;
    if (m_data_q.size() != 2 || m_data_q[0] !== 32'hAABBCCDD || m_data_q[1] !== 32'h11220000) begin
      miscompares++;
      $display("FAIL partial_be: %0d writes, first %h last %h, required 2 writes aabbccdd 11220000",
               m_data_q.size(), m_data_q[0], m_data_q[m_data_q.size()-1]);
    end
    vectors++;
    if (l_data_q.size() != 2 || l_data_q[0] !== 32'hDDCCBBAA || l_data_q[1] !== 32'h00002211) begin
      miscompares++;
      $display("FAIL partial_le: %0d writes, first %h last %h, required 2 writes ddccbbaa 00002211",
               l_data_q.size(), l_data_q[0], l_data_q[l_data_q.size()-1]);
    end
    vectors++;
    if ({m_load_done, m_core_hold, m_error} !== 3'b100) begin
      miscompares++;
      $display("FAIL partial_done: done=%b hold=%b err=%b, required 1 0 0",
               m_load_done, m_core_hold, m_error);
    end
  endtask

  task automatic test_idle_gaps;
    use_small = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(8'(i + 1), 1'b0, 1);
    @(negedge clock);
    vectors++;
    if ({m_wr_en, m_wr_addr, m_wr_data} !== {1'b1, 6'd0, 32'h01020304}) begin
      miscompares++;
      $display("FAIL gaps_write: en=%b addr=%0d data=%h, required 1 0 01020304",
               m_wr_en, m_wr_addr, m_wr_data);
    end
    repeat (4) begin @(posedge clock); #1; end
    vectors++;
    if (m_data_q.size() != 1 || m_word_count !== 7'd1 || {m_core_hold, m_load_done, m_in_ready} !== 3'b101) begin
      miscompares++;
      $display("FAIL gaps_after: writes=%0d count=%0d hold/done/rdy=%b%b%b, required 1 1 101",
               m_data_q.size(), m_word_count, m_core_hold, m_load_done, m_in_ready);
    end
  endtask

  task automatic test_overflow;
    logic [1:0] st_err;
    use_small = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) model_bytes.push_back(8'($urandom_range(0, 255)));
    build_expected(1'b1);
    for (int i = 0; i < 16; i++) send_byte(model_bytes[i], 1'b0, $urandom_range(0, 1));
    repeat (2) begin @(posedge clock); #1; end
    vectors++;
    if (s_data_q.size() != 4 || s_word_count !== 3'd4 || s_error !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_fill: writes=%0d count=%0d err=%b, required 4 4 0",
               s_data_q.size(), s_word_count, s_error);
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (s_data_q[i] !== exp_q[i] || s_addr_q[i] != i) begin
          miscompares++;
          $display("FAIL ovf_word%0d: addr %0d data %h, required addr %0d data %h",
                   i, s_addr_q[i], s_data_q[i], i, exp_q[i]);
        end
      end
    end
    send_byte(8'($urandom_range(0, 255)), 1'b0, 0);
    @(negedge clock);
    st_err = s_state;
    vectors++;
    if ({s_error, s_core_hold, s_in_ready, s_load_done, s_wr_en} !== 5'b11000) begin
      miscompares++;
      $display("FAIL ovf_error: err/hold/rdy/done/en=%b%b%b%b%b, required 11000",
               s_error, s_core_hold, s_in_ready, s_load_done, s_wr_en);
    end
    @(posedge clock); #1;
    in_valid = 1'b1; in_last = 1'b1; reload = 1'b1;
    @(posedge clock); #1;
    reload = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    in_valid = 1'b0; in_last = 1'b0;
    @(posedge clock); #1;
    vectors++;
    if (s_data_q.size() != 4 || {s_error, s_core_hold, s_in_ready, s_load_done} !== 4'b1100 || s_state !== st_err) begin
      miscompares++;
      $display("FAIL ovf_sticky: writes=%0d err/hold/rdy/done=%b%b%b%b state=%0d, required 4 1100 %0d",
               s_data_q.size(), s_error, s_core_hold, s_in_ready, s_load_done, s_state, st_err);
    end
  endtask

  task automatic test_exact_fill;
    use_small = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) model_bytes.push_back(8'($urandom_range(0, 255)));
    build_expected(1'b1);
    for (int i = 0; i < 16; i++) send_byte(model_bytes[i], (i == 15), 0);
    @(negedge clock);
    vectors++;
    if ({s_wr_en, s_wr_addr, s_wr_data} !== {1'b1, 2'd3, exp_q[3]}) begin
      miscompares++;
      $display("FAIL exact_last_write: en=%b addr=%0d data=%h, required 1 3 %h",
               s_wr_en, s_wr_addr, s_wr_data, exp_q[3]);
    end
    @(negedge clock);
    vectors++;
    if ({s_load_done, s_core_hold, s_error, s_word_count} !== {3'b100, 3'd4}) begin
      miscompares++;
      $display("FAIL exact_done: done/hold/err=%b%b%b count=%0d, required 100 4",
               s_load_done, s_core_hold, s_error, s_word_count);
    end
    use_small = 1'b0;
  endtask

  task automatic test_reload;
    use_small = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), (i == 3), 0);
    repeat (2) begin @(posedge clock); #1; end
    vectors++;
    if (m_load_done !== 1'b1) begin
      miscompares++;
      $display("FAIL reload_pre_done: done=%b, required 1", m_load_done);
    end
    reset = 1'b1; reload = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; reload = 1'b0;
    @(negedge clock);
    vectors++;
    if ({m_core_hold, m_load_done, m_error, m_in_ready, m_wr_en, m_word_count} !== {5'b10010, 7'd0}) begin
      miscompares++;
      $display("FAIL reload_with_reset: hold/done/err/rdy/en=%b%b%b%b%b count=%0d, required 10010 0",
               m_core_hold, m_load_done, m_error, m_in_ready, m_wr_en, m_word_count);
    end
    for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(0, 255)), (i == 7), 0);
    repeat (2) begin @(posedge clock); #1; end
    reload = 1'b1;
    @(posedge clock); #1;
    reload = 1'b0;
    @(negedge clock);
    vectors++;
    if ({m_core_hold, m_load_done, m_in_ready, m_word_count, m_state} !== {3'b101, 7'd0, load_code}) begin
      miscompares++;
      $display("FAIL reload_alone: hold/done/rdy=%b%b%b count=%0d state=%0d, required 101 0 %0d",
               m_core_hold, m_load_done, m_in_ready, m_word_count, m_state, load_code);
    end
    @(posedge clock); #1;
    clear_capture();
    model_bytes.delete();
    for (int i = 0; i < 4; i++) model_bytes.push_back(8'($urandom_range(0, 255)));
    build_expected(1'b1);
    send_byte(model_bytes[0], 1'b0, 0);
    send_byte(model_bytes[1], 1'b0, 0);
    reload = 1'b1;
    @(posedge clock); #1;
    reload = 1'b0;
    send_byte(model_bytes[2], 1'b0, 0);
    send_byte(model_bytes[3], 1'b0, 0);
    @(negedge clock);
    vectors++;
    if ({m_wr_en, m_wr_addr, m_wr_data} !== {1'b1, 6'd0, exp_q[0]}) begin
      miscompares++;
      $display("FAIL reload_new_load: en=%b addr=%0d data=%h, required 1 0 %h",
               m_wr_en, m_wr_addr, m_wr_data, exp_q[0]);
    end
  endtask

  task automatic test_reset_mid_word;
    use_small = 1'b0;
    do_reset();
    send_byte(8'h55, 1'b0, 0);
    send_byte(8'h66, 1'b0, 0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    vectors++;
    if (m_data_q.size() != 0 || m_word_count !== 7'd0) begin
      miscompares++;
      $display("FAIL midreset_nowrite: writes=%0d count=%0d, required 0 0", m_data_q.size(), m_word_count);
    end
    send_byte(8'hDE, 1'b0, 0);
    send_byte(8'hAD, 1'b0, 0);
    send_byte(8'hBE, 1'b0, 0);
    send_byte(8'hEF, 1'b0, 0);
    @(negedge clock);
    vectors++;
    if ({m_wr_en, m_wr_addr, m_wr_data} !== {1'b1, 6'd0, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL midreset_be: en=%b addr=%0d data=%h, required 1 0 deadbeef",
               m_wr_en, m_wr_addr, m_wr_data);
    end
    vectors++;
    if ({l_wr_en, l_wr_addr, l_wr_data} !== {1'b1, 6'd0, 32'hEFBEADDE}) begin
      miscompares++;
      $display("FAIL midreset_le: en=%b addr=%0d data=%h, required 1 0 efbeadde",
               l_wr_en, l_wr_addr, l_wr_data);
    end
  endtask

  task automatic test_random_images;
    int n;
    use_small = 1'b0;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) model_bytes.push_back(8'($urandom_range(0, 255)));
      for (int i = 0; i < n; i++) send_byte(model_bytes[i], (i == n - 1), $urandom_range(0, 2));
      @(negedge clock);
      vectors++;
      if ({m_wr_en, m_load_done, m_core_hold} !== 3'b101) begin
        miscompares++;
        $display("FAIL rand%0d_flush: en/done/hold=%b%b%b, required 101", it, m_wr_en, m_load_done, m_core_hold);
      end
      @(negedge clock);
      vectors++;
      if ({m_load_done, m_core_hold} !== 2'b10 || m_word_count !== 7'((n + 3) / 4)) begin
        miscompares++;
        $display("FAIL rand%0d_done: done/hold=%b%b count=%0d, required 10 %0d",
                 it, m_load_done, m_core_hold, m_word_count, (n + 3) / 4);
      end
      @(posedge clock); #1;
      build_expected(1'b1);
      vectors++;
      if (m_data_q.size() != exp_q.size()) begin
        miscompares++;
        $display("FAIL rand%0d_be_count: %0d writes, required %0d", it, m_data_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          vectors++;
          if (m_data_q[i] !== exp_q[i] || m_addr_q[i] != i) begin
            miscompares++;
            $display("FAIL rand%0d_be_word%0d: addr %0d data %h, required addr %0d data %h",
                     it, i, m_addr_q[i], m_data_q[i], i, exp_q[i]);
          end
        end
      end
      build_expected(1'b0);
      vectors++;
      if (l_data_q.size() != exp_q.size()) begin
        miscompares++;
        $display("FAIL rand%0d_le_count: %0d writes, required %0d", it, l_data_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          vectors++;
          if (l_data_q[i] !== exp_q[i] || l_addr_q[i] != i) begin
            miscompares++;
            $display("FAIL rand%0d_le_word%0d: addr %0d data %h, required addr %0d data %h",
                     it, i, l_addr_q[i], l_data_q[i], i, exp_q[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial_word();
    test_idle_gaps();
    test_overflow();
    test_exact_fill();
    test_reload();
    test_reset_mid_word();
    test_random_images();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Byte-stream loader that fills the instruction memory before the single-cycle MIPS core runs.
- Packs incoming 8-bit bytes into 32-bit big-endian instruction words and issues one-cycle word writes to instruction memory.
- Holds the core (PC frozen) via core_hold until the image is complete.
- Sits directly upstream of the fetch path: its write port feeds instMemory, and core_hold gates the PC register update.

Parameters:
- DEPTH, 64, number of 32-bit words in instruction memory.
- ADDR_W, 6, word-address width; must satisfy 2**ADDR_W >= DEPTH.
- BIG_ENDIAN, 1, 1 = first byte lands in [31:24] (MIPS order); 0 = first byte lands in [7:0].

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high.
- in_valid, input, 1, source has a byte on in_data.
- in_data, input, 8, stream byte.
- in_last, input, 1, qualifies the final byte of the image.
- in_ready, output, 1, loader accepts the byte this cycle.
- reload, input, 1, single-cycle request to restart loading; honoured only in DONE.
- wr_en, output, 1, instruction-memory write strobe, one cycle per word.
- wr_addr, output, ADDR_W, word address of the write.
- wr_data, output, 32, packed instruction word.
- word_count, output, ADDR_W+1, words written so far.
- core_hold, output, 1, 1 = core PC must not advance.
- load_done, output, 1, image loaded; level signal.
- error, output, 1, overflow detected; sticky until reset.

Behaviour:
- Handshake: a byte is accepted in a cycle where in_valid && in_ready. in_data and in_last are sampled only on acceptance.
- States:
  - LOAD: in_ready=1.
  - FLUSH: in_ready=0, lasts one cycle.
  - DONE: in_ready=0.
  - ERROR: in_ready=0.
- Reset: state=LOAD, lane=0, word index=0, packing register=0. Outputs: wr_en=0, wr_addr=0, wr_data=0, word_count=0, core_hold=1, load_done=0, error=0.
- Packing (LOAD): each accepted byte goes into lane 0..3.
  - BIG_ENDIAN=1: lane L maps to bits [31-8L : 24-8L].
  - Lane increments modulo 4.
- Word write:
  - Trigger: a byte is accepted on lane 3, or any byte is accepted with in_last=1.
  - Next cycle: wr_en=1, wr_addr=current word index, wr_data=packed word, word_count increments by 1.
  - A partial final word has its unfilled lanes set to 0x00.
  - After the write, lane and packing register clear to 0.
  - wr_en is a one-cycle pulse, with no back-to-back writes faster than one per 4 accepted bytes, except that in_last can force an early write.
- Latency: trigger byte accepted at cycle t gives wr_en at t+1.
- in_last transition: on an accepted byte with in_last=1, go LOAD->FLUSH. The write occurs in FLUSH, then FLUSH->DONE.
- DONE: core_hold=0 and load_done=1, first asserted at t+2 relative to the in_last byte.
- Overflow:
  - A byte accepted while word_count==DEPTH and lane==0 goes LOAD->ERROR, and that byte is discarded.
  - ERROR: error=1, core_hold=1, load_done=0, no further writes. Only reset exits ERROR.
- Exact fill: in_last on the byte that completes word DEPTH-1 is legal and leads to DONE.
- reload:
  - In DONE: next cycle state=LOAD, word_count=0, lane=0, core_hold=1, load_done=0.
  - In other states: ignored.
- Priority: reset over everything; reload has no effect when reset is asserted in the same cycle.
- in_valid while in_ready=0 has no effect. The source must hold the byte until it is accepted.
- Reset mid-word: partially packed bytes are discarded and no write is issued.

Decomposition:
- Shared package:
  - State enum: LOAD, FLUSH, DONE, ERROR.
  - Constants: BYTES_PER_WORD=4, LANE_W=2.
  - Default DEPTH/ADDR_W, shared with instMemory sizing.
- Sub-module byte_packer:
  - Inputs: lane, byte, BIG_ENDIAN, clear.
  - Output: 32-bit packing register.
  - Contains the zero-fill logic.
- FSM and counters stay in imem_boot_loader.

Test Plan:
1. Reset, then 8 bytes 0x20,0x08,0x00,0x05,0x8C,0x09,0x00,0x04 with in_last on the 8th byte. Required response:
   - wr_en pulse with addr 0, data 0x20080005.
   - wr_en pulse with addr 1, data 0x8C090004.
   - word_count=2.
   - core_hold falls 2 cycles after the last byte, and load_done=1.
2. 6 bytes 0xAA,0xBB,0xCC,0xDD,0x11,0x22 with in_last on 0x22. Required response:
   - addr 0 = 0xAABBCCDD.
   - addr 1 = 0x11220000 (zero-filled partial word).
   - DONE reached.
3. in_valid toggled every other cycle, with idle gaps, across 4 bytes 0x01..0x04. Required response: a single write of 0x01020304 one cycle after the 4th acceptance; no extra writes.
4. DEPTH=4: stream 16 bytes without in_last, then 1 more byte. Required response:
   - 4 writes at addr 0..3.
   - The 17th byte moves the block to ERROR: error=1, core_hold=1, in_ready=0.
   - A later in_last byte produces no write.
5. After DONE, pulse reload together with reset, then reload alone. Required response:
   - The combined cycle yields reset state.
   - The lone reload gives word_count=0, core_hold=1 next cycle.
   - A new 4-byte load then writes addr 0.
6. Reset asserted after 2 of 4 bytes. Required response:
   - No wr_en.
   - The next 4 bytes 0xDE,0xAD,0xBE,0xEF write 0xDEADBEEF at addr 0.
   - BIG_ENDIAN=0 run with the same bytes writes 0xEFBEADDE.
